imm_packer: RTL and testbench

- Pipelined immediate encoder: takes a sign-extended 32-bit immediate, an immediate format select, and a base instruction word carrying the non-immediate fields.
- Scatters the immediate into the format's bit positions and produces the final 32-bit instruction word.
- Range and alignment are checked so that decoding the output with the same format returns the input immediate.
- Sits on the instruction-generation path (boot/patch loader, test-program generator), upstream of instruction memory, with valid/ready handshakes on both sides.

---
 rtl/imm_packer_pkg.sv | 21 ++
 rtl/imm_packer_if.sv | 23 ++
 rtl/imm_scatter.sv | 54 +++++
 rtl/imm_packer.sv | 91 +++++++++
 tb/tb_imm_packer.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_packer_pkg.sv
// Shared definitions for the immediate packer and the matching immediate extender.
// Both ends use this one format encoding so they cannot drift apart.
package imm_packer_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  // Request payload as held in the first pipeline stage.
  typedef struct packed {
    imm_src_e          src;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   base;
  } req_t;

endpackage

// File: rtl/imm_packer_if.sv
// Request/response handshake bundle of the immediate packer.
// master = producer/consumer side, slave = the packer itself.
interface imm_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  ImmSrc;
  logic [31:0] Imm;
  logic [31:0] Base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Instr;
  logic        RangeErr;

  modport master (
    output in_valid, ImmSrc, Imm, Base, out_ready,
    input  in_ready, out_valid, Instr, RangeErr
  );

  modport slave (
    input  in_valid, ImmSrc, Imm, Base, out_ready,
    output in_ready, out_valid, Instr, RangeErr
  );
endinterface

// File: rtl/imm_scatter.sv
// Combinational immediate scatter: places Imm into the selected format's bit
// positions of Base and flags immediates that would not decode back unchanged.
module imm_scatter
  import imm_packer_pkg::*;
(
  input  imm_src_e          imm_src,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   base,
  output logic [XLEN-1:0]   instr,
  output logic              range_err
);

  // An immediate fits when every bit above the format's sign bit copies it.
  logic fits_12;
  logic fits_13;
  logic fits_21;

  assign fits_12 = (&imm[31:11]) || !(|imm[31:11]);
  assign fits_13 = (&imm[31:12]) || !(|imm[31:12]);
  assign fits_21 = (&imm[31:20]) || !(|imm[31:20]);

  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves
    // a value unassigned and no latch is inferred.
    instr     = base;
    range_err = 1'b0;
    case (imm_src)
      IMM_I: begin
        instr[31:20] = imm[11:0];
        range_err    = !fits_12;
      end
      IMM_S: begin
        instr[31:25] = imm[11:5];
        instr[11:7]  = imm[4:0];
        range_err    = !fits_12;
      end
      IMM_B: begin
        instr[31]    = imm[12];
        instr[7]     = imm[11];
        instr[30:25] = imm[10:5];
        instr[11:8]  = imm[4:1];
        range_err    = !fits_13 || imm[0];
      end
      IMM_J: begin
        instr[31]    = imm[20];
        instr[19:12] = imm[19:12];
        instr[20]    = imm[11];
        instr[30:21] = imm[10:1];
        range_err    = !fits_21 || imm[0];
      end
    endcase
  end

endmodule

// File: rtl/imm_packer.sv
// Two-stage pipelined immediate encoder with valid/ready on both sides,
// plus output-handshake and range-error counters.
module imm_packer
  import imm_packer_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  imm_packer_if.slave       bus,
  output logic [CNT_W-1:0]  EncCount,
  output logic [ERR_W-1:0]  ErrCount
);

  req_t              s1_req;
  logic              s1_valid;
  logic              s2_valid;
  logic [XLEN-1:0]   s2_instr;
  logic              s2_err;
  logic              s1_adv;
  logic              s2_adv;
  logic              accept;
  logic              emit;
  logic [XLEN-1:0]   pack_instr;
  logic              pack_err;

  // Each stage may load when it is empty or its content moves on this cycle;
  // out_ready therefore reaches in_ready combinationally.
  assign s2_adv = !s2_valid || bus.out_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign accept = bus.in_valid && s1_adv;
  assign emit   = s2_valid && bus.out_ready;

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.Instr     = s2_instr;
  assign bus.RangeErr  = s2_err;

  imm_scatter u_scatter (
    .imm_src   (s1_req.src),
    .imm       (s1_req.imm),
    .base      (s1_req.base),
    .instr     (pack_instr),
    .range_err (pack_err)
  );

  // NOTE: the S1 payload has no reset; s1_valid alone decides whether it is
  // meaningful, so clearing the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_req <= '{src: imm_src_e'(bus.ImmSrc), imm: bus.Imm, base: bus.Base};
    end
  end

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the previous cycle's values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_instr <= '0;
      s2_err   <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= bus.in_valid;
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_instr <= pack_instr;
          s2_err   <= pack_err;
        end
      end
    end
  end

  // EncCount wraps; ErrCount sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      EncCount <= '0;
      ErrCount <= '0;
    end else if (emit) begin
      EncCount <= EncCount + 1'b1;
      if (s2_err && (ErrCount != '1)) begin
        ErrCount <= ErrCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imm_packer.sv
// Self-checking bench for imm_packer: directed vectors, backpressure, reset
// mid-flight, error saturation and randomized traffic against a scoreboard.
module tb_imm_packer;
  import imm_packer_pkg::*;

  localparam int CNT_W = 16;
  localparam int ERR_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imm_packer_if bus ();
  logic [CNT_W-1:0] enc_count;
  logic [ERR_W-1:0] err_count;

  imm_packer #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .EncCount (enc_count),
    .ErrCount (err_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [1:0]  src;
    logic [31:0] imm;
  } exp_t;

  // Reference: representable range by signed arithmetic, then field placement.
  function automatic exp_t model(input logic [1:0] src, input logic [31:0] imm,
                                 input logic [31:0] base);
    exp_t   e;
    longint v;
    longint lo;
    longint hi;
    bit     even;
    v = longint'($signed(imm));
    case (src)
      2'd0, 2'd1: begin lo = -2048;      hi = 2047;        even = 1'b0; end
      2'd2:       begin lo = -4096;      hi = 4095;        even = 1'b1; end
      default:    begin lo = -(64'sd1 <<< 20); hi = (64'sd1 <<< 20) - 1; even = 1'b1; end
    endcase
    e.err   = (v < lo) || (v > hi) || (even && (v % 2 != 0));
    e.instr = base;
    case (src)
      2'd0: e.instr[31:20] = imm[11:0];
      2'd1: begin e.instr[31:25] = imm[11:5]; e.instr[11:7] = imm[4:0]; end
      2'd2: begin
        e.instr[31] = imm[12]; e.instr[7] = imm[11];
        e.instr[30:25] = imm[10:5]; e.instr[11:8] = imm[4:1];
      end
      default: begin
        e.instr[31] = imm[20]; e.instr[19:12] = imm[19:12];
        e.instr[20] = imm[11]; e.instr[30:21] = imm[10:1];
      end
    endcase
    e.src = src;
    e.imm = imm;
    return e;
  endfunction

  // Independent extender used for round-trip checks.
  function automatic logic [31:0] decode(input logic [1:0] src, input logic [31:0] w);
    case (src)
      2'd0:    return {{20{w[31]}}, w[31:20]};
      2'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
      2'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  // Scoreboard state, owned by the compare process.
  exp_t             q[$];
  logic [CNT_W-1:0] m_enc = '0;
  logic [ERR_W-1:0] m_err = '0;
  logic             prev_stall = 1'b0;
  logic [31:0]      prev_instr = '0;
  logic             prev_err = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      check("enc_count", 32'(enc_count), 32'(m_enc));
      check("err_count", 32'(err_count), 32'(m_err));
      if (prev_stall) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_instr", bus.Instr, prev_instr);
        check("hold_err", 32'(bus.RangeErr), 32'(prev_err));
      end
      if (reset) begin
        q.delete();
        m_enc = '0;
        m_err = '0;
        prev_stall = 1'b0;
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_output: got %h expected no word at %0t", bus.Instr, $time);
          end else begin
            e = q.pop_front();
            check("out_instr", bus.Instr, e.instr);
            check("out_err", 32'(bus.RangeErr), 32'(e.err));
            if (!e.err) check("round_trip", decode(e.src, bus.Instr), e.imm);
            if (e.err && m_err != '1) m_err++;
          end
          m_enc++;
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_instr = bus.Instr;
        prev_err   = bus.RangeErr;
        if (bus.in_valid && bus.in_ready) q.push_back(model(bus.ImmSrc, bus.Imm, bus.Base));
      end
    end
  end

  task automatic drive(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] base);
    bus.ImmSrc = src;
    bus.Imm    = imm;
    bus.Base   = base;
  endtask

  task automatic gen(input bit force_err, output logic [1:0] src,
                     output logic [31:0] imm, output logic [31:0] base);
    logic [31:0] r;
    int          sh;
    src  = 2'($urandom_range(0, 3));
    base = $urandom;
    if (force_err) begin
      imm = 32'h4000_0000 | 32'($urandom_range(0, 1000));
    end else begin
      r   = $urandom;
      sh  = 32 - $urandom_range(1, 24);
      imm = 32'($signed(r << sh) >>> sh);
      if ($urandom_range(0, 3) != 0) imm[0] = 1'b0;
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the
  // edge on which the word was taken.
  task automatic single(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] base,
                        input logic [31:0] exp_instr, input logic exp_err,
                        input string tag, output logic [31:0] got);
    int   lat;
    exp_t m;
    m = model(src, imm, base);
    check({tag, "_model_instr"}, m.instr, exp_instr);
    check({tag, "_model_err"}, 32'(m.err), 32'(exp_err));
    drive(src, imm, base);
    bus.in_valid = 1'b1;
    @(negedge clk);
    check({tag, "_accept"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd2);
    check({tag, "_instr"}, bus.Instr, exp_instr);
    check({tag, "_err"}, 32'(bus.RangeErr), 32'(exp_err));
    got = bus.Instr;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while ((q.size() != 0 || bus.out_valid) && n < limit) begin
      @(posedge clk);
      #1 n++;
    end
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  logic [1:0]  bp_src [5];
  logic [31:0] bp_imm [5];
  logic [31:0] bp_base[5];

  initial begin
    logic [31:0] got;
    logic [1:0]  s;
    logic [31:0] im;
    logic [31:0] bs;
    logic [CNT_W-1:0] enc0;
    int idx;
    int guard;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(2'd0, '0, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_instr", bus.Instr, 32'd0);
    check("rst_range_err", 32'(bus.RangeErr), 32'd0);
    check("rst_enc", 32'(enc_count), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;

    single(2'b00, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0, "i_neg", got);
    single(2'b01, 32'h0000_007F, 32'h0000_2023, 32'h0600_2FA3, 1'b0, "s_pos", got);
    single(2'b10, 32'hFFFF_FFFE, 32'h0000_0063, 32'hFE00_0FE3, 1'b0, "b_neg", got);
    check("b_extend", decode(2'b10, got), 32'hFFFF_FFFE);
    single(2'b11, 32'h0000_0003, 32'h0000_006F, 32'h0020_006F, 1'b1, "j_odd", got);
    check("j_odd_errcnt", 32'(err_count), 32'd1);
    single(2'b00, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1, "i_big", got);
    check("i_big_errcnt", 32'(err_count), 32'd2);
    check("directed_enccnt", 32'(enc_count), 32'd5);

    // Backpressure: five requests against a stalled consumer.
    enc0 = enc_count;
    for (int i = 0; i < 5; i++) gen(1'b0, bp_src[i], bp_imm[i], bp_base[i]);
    bus.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      drive(bp_src[idx], bp_imm[idx], bp_base[idx]);
      bus.in_valid = 1'b1;
      @(negedge clk);
      if (bus.in_ready) idx++;
      @(posedge clk);
      #1;
    end
    check("bp_accepts", 32'(idx), 32'd2);
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    guard = 0;
    while (idx < 5 && guard < 20) begin
      drive(bp_src[idx], bp_imm[idx], bp_base[idx]);
      bus.in_valid = 1'b1;
      @(negedge clk);
      if (bus.in_ready) idx++;
      @(posedge clk);
      #1 guard++;
    end
    check("bp_all_sent", 32'(idx), 32'd5);
    drain(20);
    check("bp_enccnt", 32'(enc_count - enc0), 32'd5);

    // Reset with both stages occupied.
    bus.out_ready = 1'b0;
    idx = 0;
    guard = 0;
    while (idx < 2 && guard < 10) begin
      gen(1'b0, s, im, bs);
      drive(s, im, bs);
      bus.in_valid = 1'b1;
      @(negedge clk);
      if (bus.in_ready) idx++;
      @(posedge clk);
      #1 guard++;
    end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_enc", 32'(enc_count), 32'd0);
    check("mid_rst_err", 32'(err_count), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Error counter saturation.
    idx = 0;
    guard = 0;
    gen(1'b1, s, im, bs);
    while (idx < 300 && guard < 1000) begin
      drive(s, im, bs);
      bus.in_valid = 1'b1;
      @(negedge clk);
      if (bus.in_ready) begin
        idx++;
        gen(1'b1, s, im, bs);
      end
      @(posedge clk);
      #1 guard++;
    end
    drain(20);
    check("sat_sent", 32'(idx), 32'd300);
    check("sat_errcnt", 32'(err_count), 32'd255);

    // Randomized traffic with random backpressure.
    gen(1'b0, s, im, bs);
    for (int c = 0; c < 3000; c++) begin
      drive(s, im, bs);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) gen($urandom_range(0, 7) == 0, s, im, bs);
      @(posedge clk);
      #1;
    end
    drain(20);
    check("final_errcnt_sat", 32'(err_count), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
